// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle add/subtract, DIGIT bits per clock
// through a small ripple chain with a registered inter-digit carry.
module serial_adder_n #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH ||
       (WIDTH % DIGIT) != 0) begin : g_param_err
      $error("serial_adder_n: illegal WIDTH/DIGIT");
   end

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic [DIGIT-1:0] dig_d;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] bsel_d;
   logic             dcar_d;
   logic             cmsb_d;
   logic             rc;

   // cmsb_d ends up holding the carry into the top bit of the digit
   always_comb begin
      rc     = carry_q;
      dig_d  = '0;
      cmsb_d = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         cmsb_d   = rc;
         dig_d[i] = a_q[i] ^ b_q[i] ^ rc;
         rc       = (a_q[i] & b_q[i]) | (rc & a_q[i]) |
                    (rc & b_q[i]);
      end
      dcar_d = rc;
      res_d  = res_q >> DIGIT;
      res_d[WIDTH-1 -: DIGIT] = dig_d;
      bsel_d = sub ? ~b : b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  a_q     <= a;
                  b_q     <= bsel_d;
                  carry_q <= cin ^ sub;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               res_q   <= res_d;
               carry_q <= dcar_d;
               if (cnt_q == LAST) begin
                  state_q <= S_DONE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  sum_q   <= res_d;
                  cout_q  <= dcar_d;
                  ovf_q   <= cmsb_d ^ dcar_d;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule
